systolic_feeder: RTL and testbench
==================================

// Module: systolic_feeder
// PURPOSE
//  Operand load/skew stage between the input FIFO and the systolic array.
//  - Read phase (read_start): pops array_size operand words from the FIFO into a local buffer, then pulses read_done.
//  - Compute phase (compute_start): streams the buffer into the array edges with diagonal skew, then pulses compute_done.
//  Driven directly by systolic_control's read_start/compute_start; its done pulses advance that FSM.
// PARAMETERS
//  datawith    16  bits per operand element
//  array_size  2   PE rows = PE cols = operand words per load (>=2)
// PORTS
//  clk            in   1                      clock, all logic on rising edge
//  rst            in   1                      asynchronous, active-high reset
//  read_start     in   1                      level, high while controller is in its read state
//  compute_start  in   1                      level, high while controller is in its compute state
//  rempty         in   1                      input FIFO empty
//  fifo_rdata     in   2*array_size*datawith  FIFO word r = {B[r][N-1..0], A[N-1..0][r]}; weight half is the upper half
//  fifo_rd_en     out  1                      FIFO pop; data valid on fifo_rdata the following cycle
//  read_done      out  1                      1-cycle pulse, buffer full
//  compute_done   out  1                      1-cycle pulse, feed + drain finished
//  data_out       out  array_size*datawith    lane i -> array row i (left edge)
//  weight_out     out  array_size*datawith    lane j -> array column j (top edge)
//  lane_valid     out  array_size             bit i: data lane i and weight lane i are carrying a real element
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, counters cleared; buffer contents don't-care.
//  FSM: IDLE -> LOAD (read_start=1); LOAD -> LOADED (N-th word captured); LOADED -> FEED (compute_start=1);
//       FEED -> IDLE (t = 3N-2). LOAD -> IDLE if read_start drops before the buffer is full: counts cleared, in-flight word discarded.
//  LOAD:
//  - fifo_rd_en = !rempty && req_cnt < N (combinational).
//  - req_cnt increments on each pop.
//  - Word is captured the cycle after a pop into buffer[cap_cnt]; cap_cnt then increments.
//  - rempty high: no pop, stall indefinitely, no data lost.
//  - Cycle in which cap_cnt reaches N: read_done=1 for exactly 1 cycle. FSM enters LOADED, so no duplicate pulse.
//  - Best-case latency: read_start rising -> read_done = N+1 cycles.
//  - fifo_rd_en is never asserted outside LOAD.
//  FEED:
//  - t counts 0 .. 3N-2, one increment per cycle; outputs are registered.
//  - Data lane i: A[i][t-i], from buffer word (t-i), data half, element i.
//  - Weight lane j: B[t-j][j], from buffer word (t-j), weight half, element j.
//  - Element index k = t-lane. If 0 <= k < N: lane_valid=1; otherwise the lane outputs 0 and lane_valid=0.
//  - t >= 2N-1: drain; all lanes 0/invalid.
//  - compute_done=1 during the cycle with t = 3N-2; next state IDLE.
//  Ignored inputs: compute_start outside LOADED/FEED; read_start outside IDLE/LOAD. compute_start dropping mid-FEED does not abort.
//  Simultaneous read_start and compute_start in IDLE: the read has priority.
//  Counters are $clog2(3N) bits wide, with no wrap inside a phase.
//  rst asserted mid-operation: immediate return to reset state; a partial load is lost.
// CONFIGURATION
//  FEEDER_STALL_CNT_EN defined:
//  - Adds output stall_cnt [31:0]: counts cycles in LOAD with rempty=1.
//  - Saturates at 2^32-1, cleared by rst only.
//  FEEDER_STALL_CNT_EN undefined: port and counter absent; behaviour otherwise identical.
// TESTING (N=2, datawith=16)
//  1. Basic load:
//     - FIFO holds w0 = {B00=5,B01=6 | A10=3,A00=1} and w1 = {B10=7,B11=8 | A11=4,A01=2}; read_start held.
//     - Required: fifo_rd_en high 2 cycles; read_done pulse 3 cycles after read_start.
//  2. Feed order after test 1, compute_start held:
//     - t0: data {0,1}, wt {0,5}, valid 01.
//     - t1: data {3,2}, wt {6,7}, valid 11.
//     - t2: data {4,0}, wt {8,0}, valid 10.
//     - t3..t4: zeros, valid 00.
//     - compute_done pulse at t4.
//  3. FIFO underflow: rempty=1 for 5 cycles between the two words.
//     - Required: no pop while empty; read_done delayed exactly 5 cycles; buffer correct.
//     - With FEEDER_STALL_CNT_EN: stall_cnt=5.
//  4. Abort/reset:
//     - read_start drops after 1 pop -> IDLE; a new load starts from word 0.
//     - rst mid-FEED -> all outputs 0 the same cycle; no compute_done.
//  5. Back-to-back: two full load/feed rounds.
//     - Required: exactly one read_done and one compute_done per round.
//     - compute_start arriving during LOAD is ignored.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// ============================================================================
// systolic_feeder_if : FIFO-side and array-side bus of the systolic feeder
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface systolic_feeder_if #(
  parameter int DATAWITH   = 16,
  parameter int ARRAY_SIZE = 2
);
  logic                               read_start;
  logic                               compute_start;
  logic                               rempty;
  logic [2*ARRAY_SIZE*DATAWITH-1:0]   fifo_rdata;
  logic                               fifo_rd_en;
  logic                               read_done;
  logic                               compute_done;
  logic [ARRAY_SIZE*DATAWITH-1:0]     data_out;
  logic [ARRAY_SIZE*DATAWITH-1:0]     weight_out;
  logic [ARRAY_SIZE-1:0]              lane_valid;

  // Controller / FIFO / array side
  modport master (
    output read_start, compute_start, rempty, fifo_rdata,
    input  fifo_rd_en, read_done, compute_done, data_out, weight_out, lane_valid
  );

  // Feeder side
  modport slave (
    input  read_start, compute_start, rempty, fifo_rdata,
    output fifo_rd_en, read_done, compute_done, data_out, weight_out, lane_valid
  );
endinterface

`default_nettype wire

// File: rtl/systolic_feeder.sv
// ============================================================================
// systolic_feeder : loads N operand words from the FIFO, then streams them
//                   diagonally skewed into the systolic array edges.
// Optional macro FEEDER_STALL_CNT_EN adds the stall_cnt output.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_feeder #(
  parameter int DATAWITH   = 16,
  parameter int ARRAY_SIZE = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  systolic_feeder_if.slave   bus
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int N    = ARRAY_SIZE;
  localparam int W    = DATAWITH;
  localparam int CW   = $clog2(3 * N);
  localparam int IW   = $clog2(N);
  localparam logic [CW-1:0] C_N    = CW'(N);
  localparam logic [CW-1:0] C_NM1  = CW'(N - 1);
  localparam logic [CW-1:0] C_LAST = CW'(3 * N - 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_LOADED = 2'd2,
    S_FEED   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    req_q, req_d;
  logic [CW-1:0]    cap_q, cap_d;
  logic [CW-1:0]    t_q, t_d;
  logic             pop_q, pop_d;
  logic             rd_en, rdone, wr_buf, feed_d, done_d;

  logic [2*N*W-1:0] buf_q [N];
  logic [N*W-1:0]   data_q, data_d;
  logic [N*W-1:0]   wt_q, wt_d;
  logic [N-1:0]     valid_q, valid_d;
  logic             done_q;
  logic [CW-1:0]    k;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cap_d   = cap_q;
    t_d     = t_q;
    pop_d   = 1'b0;
    rd_en   = 1'b0;
    rdone   = 1'b0;
    wr_buf  = 1'b0;
    feed_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_d = '0;
        cap_d = '0;
        t_d   = '0;
        if (bus.read_start) state_d = S_LOAD;
      end
      S_LOAD: begin
        rd_en = bus.read_start && !bus.rempty && (req_q < C_N);
        pop_d = rd_en;
        if (rd_en) req_d = req_q + 1'b1;
        // Capture lands one cycle after the pop; the last capture completes the load
        // even if read_start drops in that same cycle.
        if (pop_q && cap_q == C_NM1) begin
          wr_buf  = 1'b1;
          cap_d   = cap_q + 1'b1;
          rdone   = 1'b1;
          state_d = S_LOADED;
        end else if (!bus.read_start) begin
          req_d   = '0;
          cap_d   = '0;
          pop_d   = 1'b0;
          state_d = S_IDLE;
        end else if (pop_q) begin
          wr_buf = 1'b1;
          cap_d  = cap_q + 1'b1;
        end
      end
      S_LOADED: begin
        if (bus.compute_start) begin
          state_d = S_FEED;
          t_d     = '0;
          feed_d  = 1'b1;
        end
      end
      S_FEED: begin
        if (t_q == C_LAST) begin
          state_d = S_IDLE;
          t_d     = '0;
        end else begin
          t_d    = t_q + 1'b1;
          feed_d = 1'b1;
          done_d = (t_d == C_LAST);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lane values are computed from the next t so the registered outputs line up with t.
  always_comb begin
    data_d  = '0;
    wt_d    = '0;
    valid_d = '0;
    k       = '0;
    if (feed_d) begin
      for (int i = 0; i < N; i++) begin
        k = t_d - CW'(i);
        if (t_d >= CW'(i) && k < C_N) begin
          valid_d[i]           = 1'b1;
          data_d[i*W +: W]     = buf_q[k[IW-1:0]][i*W +: W];
          wt_d[i*W +: W]       = buf_q[k[IW-1:0]][(N+i)*W +: W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cap_q   <= '0;
      t_q     <= '0;
      pop_q   <= 1'b0;
      data_q  <= '0;
      wt_q    <= '0;
      valid_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cap_q   <= cap_d;
      t_q     <= t_d;
      pop_q   <= pop_d;
      data_q  <= data_d;
      wt_q    <= wt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_buf) buf_q[cap_q[IW-1:0]] <= bus.fifo_rdata;
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;

  // A stall is a cycle where a pop is wanted but the FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == S_LOAD && bus.read_start && bus.rempty &&
                 req_q < C_N && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign bus.fifo_rd_en   = rd_en;
  assign bus.read_done    = rdone;
  assign bus.compute_done = done_q;
  assign bus.data_out     = data_q;
  assign bus.weight_out   = wt_q;
  assign bus.lane_valid   = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
// ============================================================================
// tb_systolic_feeder : scoreboard bench for systolic_feeder (N=2, 16-bit)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_feeder_if #(.DATAWITH(16), .ARRAY_SIZE(2)) bus ();

`ifdef FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt;
  systolic_feeder #(.DATAWITH(16), .ARRAY_SIZE(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .stall_cnt(stall_cnt)
  );
`else
  systolic_feeder #(.DATAWITH(16), .ARRAY_SIZE(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
`endif

  typedef struct {
    int          cyc;
    logic        rd;
    logic        cd;
    logic [31:0] d;
    logic [31:0] w;
    logic [1:0]  v;
    int          scnt;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  logic end_req = 1'b0;

  // FIFO model: stimulus owns wp, the pop process owns rp
  logic [63:0] mem [32];
  int wp = 0;
  int rp = 0;
  assign bus.rempty = (rp == wp);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.fifo_rd_en && rp != wp) begin
      bus.fifo_rdata <= mem[rp];
      rp <= rp + 1;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (bus.fifo_rd_en || bus.read_done || bus.compute_done || bus.data_out != 0 ||
          bus.weight_out != 0 || bus.lane_valid != 0) begin
        errors++;
        $display("FAIL rst_zero cyc=%0d: rd_en=%b rd=%b cd=%b data=%h wt=%h v=%b, required all 0",
                 cyc, bus.fifo_rd_en, bus.read_done, bus.compute_done, bus.data_out,
                 bus.weight_out, bus.lane_valid);
      end
    end else begin
      if (bus.fifo_rd_en) begin
        pops++;
        checks++;
        if (bus.rempty) begin
          errors++;
          $display("FAIL pop_while_empty cyc=%0d: rd_en=1 rempty=1, required no pop", cyc);
        end
      end
      if (bus.read_done || bus.compute_done || bus.lane_valid != 0 ||
          bus.data_out != 0 || bus.weight_out != 0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d: rd=%b cd=%b data=%h wt=%h v=%b, required none",
                   cyc, bus.read_done, bus.compute_done, bus.data_out, bus.weight_out, bus.lane_valid);
        end else begin
          e_m = sb.pop_front();
          if (e_m.cyc != cyc || e_m.rd !== bus.read_done || e_m.cd !== bus.compute_done ||
              e_m.d !== bus.data_out || e_m.w !== bus.weight_out || e_m.v !== bus.lane_valid) begin
            errors++;
            $display("FAIL event: got cyc=%0d rd=%b cd=%b data=%h wt=%h v=%b, required cyc=%0d rd=%b cd=%b data=%h wt=%h v=%b",
                     cyc, bus.read_done, bus.compute_done, bus.data_out, bus.weight_out, bus.lane_valid,
                     e_m.cyc, e_m.rd, e_m.cd, e_m.d, e_m.w, e_m.v);
          end
`ifdef FEEDER_STALL_CNT_EN
          if (e_m.rd) begin
            checks++;
            if (stall_cnt != e_m.scnt) begin
              errors++;
              $display("FAIL stall_cnt cyc=%0d: got %0d, required %0d", cyc, stall_cnt, e_m.scnt);
            end
          end
`endif
        end
      end
    end
    if (end_req) begin
      checks++;
      if (pops != 13) begin
        errors++;
        $display("FAIL pop_count: got %0d, required 13", pops);
      end
      while (sb.size() != 0) begin
        e_m = sb.pop_front();
        errors++;
        $display("FAIL missing_event: required cyc=%0d rd=%b cd=%b v=%b never seen",
                 e_m.cyc, e_m.rd, e_m.cd, e_m.v);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic rd, input logic cd, input logic [31:0] d,
                      input logic [31:0] w, input logic [1:0] v, input int scnt);
    exp_t e;
    e.cyc = c; e.rd = rd; e.cd = cd; e.d = d; e.w = w; e.v = v; e.scnt = scnt;
    sb.push_back(e);
  endtask

  // Expected skewed stream when compute_start is accepted at cycle c (LOADED).
  task automatic push_feed(input int c, input logic [15:0] a00, a10, a01, a11,
                           input logic [15:0] b00, b01, b10, b11);
    push(c + 1, 1'b0, 1'b0, {16'd0, a00}, {16'd0, b00}, 2'b01, 0);
    push(c + 2, 1'b0, 1'b0, {a10, a01},   {b01, b10},   2'b11, 0);
    push(c + 3, 1'b0, 1'b0, {a11, 16'd0}, {b11, 16'd0}, 2'b10, 0);
    push(c + 5, 1'b0, 1'b1, 32'd0,        32'd0,        2'b00, 0);
  endtask

  // Word r = {B[r][1], B[r][0], A[1][r], A[0][r]}
  task automatic fifo_put(input logic [15:0] a0r, a1r, br0, br1);
    mem[wp] = {br1, br0, a1r, a0r};
    wp = wp + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int s;
  int c;

  initial begin
    bus.read_start    = 1'b0;
    bus.compute_start = 1'b0;
    bus.fifo_rdata    = '0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Basic load then feed
    fifo_put(16'd1, 16'd3, 16'd5, 16'd6);
    fifo_put(16'd2, 16'd4, 16'd7, 16'd8);
    s = cyc;
    bus.read_start = 1'b1;
    push(s + 3, 1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 0);
    tick(4);
    bus.read_start = 1'b0;
    c = cyc;
    bus.compute_start = 1'b1;
    push_feed(c, 16'd1, 16'd3, 16'd2, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
    tick(6);
    bus.compute_start = 1'b0;
    tick(2);

    // FIFO empty for 5 cycles between the two words
    fifo_put(16'd9, 16'd10, 16'd11, 16'd12);
    s = cyc;
    bus.read_start = 1'b1;
    push(s + 8, 1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 5);
    tick(7);
    fifo_put(16'd13, 16'd14, 16'd15, 16'd16);
    tick(2);
    bus.read_start = 1'b0;
    c = cyc;
    bus.compute_start = 1'b1;
    push_feed(c, 16'd9, 16'd10, 16'd13, 16'd14, 16'd11, 16'd12, 16'd15, 16'd16);
    tick(6);
    bus.compute_start = 1'b0;
    tick(2);

    // Abort after one pop, then a fresh load must start from buffer word 0
    fifo_put(16'hdead, 16'hdead, 16'hdead, 16'hdead);
    bus.read_start = 1'b1;
    tick(2);
    bus.read_start = 1'b0;
    tick(3);
    fifo_put(16'd21, 16'd22, 16'd23, 16'd24);
    fifo_put(16'd25, 16'd26, 16'd27, 16'd28);
    s = cyc;
    bus.read_start = 1'b1;
    push(s + 3, 1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 5);
    tick(4);
    bus.read_start = 1'b0;
    c = cyc;
    bus.compute_start = 1'b1;
    push_feed(c, 16'd21, 16'd22, 16'd25, 16'd26, 16'd23, 16'd24, 16'd27, 16'd28);
    tick(6);
    bus.compute_start = 1'b0;
    tick(2);

    // Back-to-back round A: read and compute requested together, compute held through LOAD
    fifo_put(16'd31, 16'd32, 16'd33, 16'd34);
    fifo_put(16'd35, 16'd36, 16'd37, 16'd38);
    s = cyc;
    bus.read_start    = 1'b1;
    bus.compute_start = 1'b1;
    push(s + 3, 1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 5);
    push_feed(s + 4, 16'd31, 16'd32, 16'd35, 16'd36, 16'd33, 16'd34, 16'd37, 16'd38);
    tick(4);
    bus.read_start = 1'b0;
    tick(6);
    bus.compute_start = 1'b0;

    // Round B immediately after
    fifo_put(16'd41, 16'd42, 16'd43, 16'd44);
    fifo_put(16'd45, 16'd46, 16'd47, 16'd48);
    s = cyc;
    bus.read_start = 1'b1;
    push(s + 3, 1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 5);
    tick(4);
    bus.read_start = 1'b0;
    c = cyc;
    bus.compute_start = 1'b1;
    push_feed(c, 16'd41, 16'd42, 16'd45, 16'd46, 16'd43, 16'd44, 16'd47, 16'd48);
    tick(6);
    bus.compute_start = 1'b0;
    tick(2);

    // Reset mid-FEED: only t0 appears, never compute_done
    fifo_put(16'd51, 16'd52, 16'd53, 16'd54);
    fifo_put(16'd55, 16'd56, 16'd57, 16'd58);
    s = cyc;
    bus.read_start = 1'b1;
    push(s + 3, 1'b1, 1'b0, 32'd0, 32'd0, 2'b00, 5);
    tick(4);
    bus.read_start = 1'b0;
    c = cyc;
    bus.compute_start = 1'b1;
    push(c + 1, 1'b0, 1'b0, {16'd0, 16'd51}, {16'd0, 16'd53}, 2'b01, 0);
    tick(2);
    #2;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(6);
    bus.compute_start = 1'b0;
    tick(2);

    end_req = 1'b1;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
